// File: rtl/spu_sm_xsub_pkg.sv
// Shared SPU softmax definitions: lane geometry, running-max floor,
// xsub FSM state encoding and the per-lane distance helper.
package spu_sm_xsub_pkg;

  localparam int SM_DW    = 8;
  localparam int SM_LANES = 4;

  // Tracker floor; -128 is excluded so max - x always fits in 8 unsigned bits.
  localparam logic signed [SM_DW-1:0] SM_MAX_INIT = 8'sb1000_0001;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } sm_state_e;

  // max - x evaluated at 9 bits, then truncated. The result is 0..255 when max >= x,
  // and the -127 floor only ever sits one above a -128 lane.
  function automatic logic [SM_DW-1:0] sm_dist(input logic signed [SM_DW-1:0] mx,
                                               input logic signed [SM_DW-1:0] x);
    logic signed [SM_DW:0] d;
    d = {mx[SM_DW-1], mx} - {x[SM_DW-1], x};
    return d[SM_DW-1:0];
  endfunction

endpackage

// File: rtl/spu_sm_rowbuf.sv
// Row buffer for the softmax xsub engine.
// Ports: core_clk; wr_en/wr_addr/wr_data synchronous write port;
//        rd_addr/rd_data asynchronous read port. Contents are not reset.
module spu_sm_rowbuf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 32
) (
  input  logic          core_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge core_clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/spu_sm_xsub.sv
// Softmax pass-2 engine: buffers a row of 4-lane int8 beats while driving the
// external running-max tracker, then replays the row emitting max - x per lane.
// Ports: core_clk/rst_n; in_* input stream (valid/ready/last, 4 lanes);
//        comp_en/comp_rst/max_in tracker interface; out_* output stream
//        (valid/ready/last, 4 unsigned distances); ovf truncation pulse; busy.
module spu_sm_xsub
  import spu_sm_xsub_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         core_clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [7:0]   in_data_0,
  input  logic [7:0]   in_data_1,
  input  logic [7:0]   in_data_2,
  input  logic [7:0]   in_data_3,
  output logic         comp_en,
  output logic         comp_rst,
  input  logic [7:0]   max_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [7:0]   out_diff_0,
  output logic [7:0]   out_diff_1,
  output logic [7:0]   out_diff_2,
  output logic [7:0]   out_diff_3,
  output logic         ovf,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;            // count must reach DEPTH
  localparam int BW = SM_LANES * SM_DW;

  sm_state_e       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [BW-1:0]   out_diff_q, out_diff_d;
  logic            ovf_q, ovf_d;
  logic            wr_en;
  logic [BW-1:0]   wr_data, rd_data;

  assign wr_data = {in_data_3, in_data_2, in_data_1, in_data_0};

  spu_sm_rowbuf #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (BW)
  ) u_rowbuf (
    .core_clk (core_clk),
    .wr_en    (wr_en),
    .wr_addr  (count_q[AW-1:0]),
    .wr_data  (wr_data),
    .rd_addr  (rd_ptr_q[AW-1:0]),
    .rd_data  (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_diff_d  = out_diff_q;
    ovf_d       = 1'b0;
    in_ready    = 1'b0;
    comp_en     = 1'b0;
    comp_rst    = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en   = 1'b1;
          comp_en = 1'b1;
          count_d = count_q + CW'(1);
          if (in_last) begin
            state_d = DRAIN;
          end else if (count_q == CW'(DEPTH - 1)) begin
            // buffer full: close the row here and flag the truncation
            state_d = DRAIN;
            ovf_d   = 1'b1;
          end
        end
      end

      DRAIN: begin
        if (out_valid_q && out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          state_d     = CLEAR;
        end else if ((!out_valid_q || out_ready) && (rd_ptr_q < count_q)) begin
          out_valid_d = 1'b1;
          out_last_d  = (rd_ptr_q == count_q - CW'(1));
          rd_ptr_d    = rd_ptr_q + CW'(1);
          for (int k = 0; k < SM_LANES; k++) begin
            out_diff_d[k*SM_DW +: SM_DW] = sm_dist(max_in, rd_data[k*SM_DW +: SM_DW]);
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end

      CLEAR: begin
        comp_rst = 1'b1;
        count_d  = '0;
        rd_ptr_d = '0;
        state_d  = LOAD;
      end

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_diff_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_diff_q  <= out_diff_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_diff_0 = out_diff_q[7:0];
  assign out_diff_1 = out_diff_q[15:8];
  assign out_diff_2 = out_diff_q[23:16];
  assign out_diff_3 = out_diff_q[31:24];
  assign ovf        = ovf_q;
  assign busy       = (state_q != LOAD) || (count_q != '0);

endmodule
